// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage driving a req/ack data memory, stalling upstream while an access is outstanding
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inRegwrite,
  input  logic        inMemtoreg,
  input  logic        inMemwrite,
  input  logic        inMemread,
  input  logic [31:0] inResult,
  input  logic [31:0] inForward,
  input  logic [4:0]  inRdout,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        stall,
  output logic        memErr,
  output logic        outRegwrite,
  output logic        outMemtoreg,
  output logic [31:0] outReadData,
  output logic [31:0] outResult,
  output logic [4:0]  MemWbRd
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic access, mis, go, done, tmo, squash;
  always_comb begin
    access    = inMemread | inMemwrite;
    mis       = (state == IDLE) & access & (inResult[1:0] != 2'b00);
    go        = (state == IDLE) & access & !mis;
    done      = (state == ACCESS) & memAck;
    tmo       = (state == ACCESS) & !memAck & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    squash    = mis | tmo;
    stall     = go | ((state == ACCESS) & !memAck & !tmo);
    state_nxt = go ? ACCESS : (done | tmo) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // stall doubles as the bubble condition for the MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      memErr      <= 1'b0;
      outRegwrite <= 1'b0;
      outMemtoreg <= 1'b0;
      outReadData <= '0;
      outResult   <= '0;
      MemWbRd     <= '0;
    end else begin
      if (go) begin
        memReq   <= 1'b1;
        memWe    <= inMemwrite;
        memAddr  <= inResult;
        memWdata <= inForward;
      end else if (done | tmo) memReq <= 1'b0;
      cnt         <= go ? '0 : ((state == ACCESS) && cnt != '1) ? cnt + 1'b1 : cnt;
      memErr      <= memErr | squash;
      outRegwrite <= !stall & !squash & inRegwrite;
      outMemtoreg <= !stall & inMemtoreg;
      outResult   <= stall ? '0 : inResult;
      MemWbRd     <= stall ? '0 : inRdout;
      outReadData <= (done & !memWe) ? memRdata : '0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the MEM stage handshake, stalls, timeout and misalignment
module tb_mem_access_stage;
  logic clk = 0, rst = 1;
  logic inRegwrite = 0, inMemtoreg = 0, inMemwrite = 0, inMemread = 0;
  logic [31:0] inResult = 0, inForward = 0, memRdata = 0;
  logic [4:0] inRdout = 0;
  logic memAck = 0;
  logic memReq, memWe, stall, memErr, outRegwrite, outMemtoreg;
  logic [31:0] memAddr, memWdata, outReadData, outResult;
  logic [4:0] MemWbRd;
  int checks = 0, failures = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .inRegwrite(inRegwrite), .inMemtoreg(inMemtoreg), .inMemwrite(inMemwrite), .inMemread(inMemread),
    .inResult(inResult), .inForward(inForward), .inRdout(inRdout),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck), .stall(stall), .memErr(memErr),
    .outRegwrite(outRegwrite), .outMemtoreg(outMemtoreg), .outReadData(outReadData),
    .outResult(outResult), .MemWbRd(MemWbRd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {inRegwrite, inMemtoreg, inMemwrite, inMemread} = '0;
    inResult = 0; inForward = 0; inRdout = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_req", 32'(memReq), 0);
    chk("rst_err", 32'(memErr), 0);
    chk("rst_rw", 32'(outRegwrite), 0);
    chk("rst_res", outResult, 0);
    chk("rst_stall", 32'(stall), 0);

    inRegwrite = 1; inResult = 32'hAA; inRdout = 5;
    #1 chk("alu_stall", 32'(stall), 0);
    tick();
    chk("alu_rw", 32'(outRegwrite), 1);
    chk("alu_res", outResult, 32'hAA);
    chk("alu_rd", 32'(MemWbRd), 5);
    chk("alu_req", 32'(memReq), 0);

    inMemtoreg = 1; inMemread = 1; inResult = 32'h100; inRdout = 7;
    #1 chk("ld_stall0", 32'(stall), 1);
    tick();
    chk("ld_req", 32'(memReq), 1);
    chk("ld_we", 32'(memWe), 0);
    chk("ld_addr", memAddr, 32'h100);
    chk("ld_bub0", 32'(outRegwrite), 0);
    chk("ld_stall1", 32'(stall), 1);
    tick();
    chk("ld_stall2", 32'(stall), 1);
    chk("ld_bub1", 32'(outRegwrite), 0);
    tick();
    memAck = 1; memRdata = 32'hDEADBEEF;
    #1 chk("ld_stall3", 32'(stall), 0);
    tick();
    memAck = 0; clr();
    chk("ld_data", outReadData, 32'hDEADBEEF);
    chk("ld_m2r", 32'(outMemtoreg), 1);
    chk("ld_rw", 32'(outRegwrite), 1);
    chk("ld_rd", 32'(MemWbRd), 7);
    chk("ld_reqoff", 32'(memReq), 0);

    inMemwrite = 1; inResult = 32'h204; inForward = 32'h12345678;
    #1 chk("st_stall0", 32'(stall), 1);
    tick();
    chk("st_req", 32'(memReq), 1);
    chk("st_we", 32'(memWe), 1);
    chk("st_addr", memAddr, 32'h204);
    chk("st_wdata", memWdata, 32'h12345678);
    memAck = 1; memRdata = 32'hFFFFFFFF;
    #1 chk("st_stall1", 32'(stall), 0);
    tick();
    memAck = 0; clr();
    chk("st_rdata", outReadData, 0);
    chk("st_reqoff", 32'(memReq), 0);
    chk("st_err", 32'(memErr), 0);

    inMemread = 1; inRegwrite = 1; inResult = 32'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(memReq), 1);
      chk("to_stall", 32'(stall), (i == 3) ? 0 : 1);
      chk("to_err0", 32'(memErr), 0);
      if (i == 3) clr();
      tick();
    end
    chk("to_reqoff", 32'(memReq), 0);
    chk("to_err", 32'(memErr), 1);
    chk("to_rw", 32'(outRegwrite), 0);
    chk("to_stall_end", 32'(stall), 0);
    memAck = 1; memRdata = 32'h55AA55AA;
    tick();
    memAck = 0;
    chk("stray_req", 32'(memReq), 0);
    chk("stray_data", outReadData, 0);
    chk("stray_err", 32'(memErr), 1);

    inMemread = 1; inResult = 32'h400;
    tick();
    chk("mr_req", 32'(memReq), 1);
    rst = 1; clr(); memAck = 1;
    tick(); tick();
    rst = 0; memAck = 0;
    chk("mr_req0", 32'(memReq), 0);
    chk("mr_err0", 32'(memErr), 0);
    chk("mr_stall", 32'(stall), 0);
    chk("mr_data", outReadData, 0);
    tick();
    chk("mr_idle_req", 32'(memReq), 0);

    inMemread = 1; inRegwrite = 1; inResult = 32'h102;
    #1 chk("mis_stall", 32'(stall), 0);
    tick();
    clr();
    chk("mis_req", 32'(memReq), 0);
    chk("mis_err", 32'(memErr), 1);
    chk("mis_rw", 32'(outRegwrite), 0);
    chk("mis_res", outResult, 32'h102);
    tick();
    chk("mis_sticky", 32'(memErr), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer side of the EX/MEM pipeline register: the MEM stage of the 5-stage pipeline.
- Takes EX/MEM control and data fields and runs data-memory loads/stores over a req/ack handshake to a multi-cycle data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Drives the MEM/WB pipeline register fields consumed by write-back and the forwarding unit.

Parameters:
TIMEOUT_CYCLES, 255, max ACCESS cycles without memAck before abort (1..2^CNT_W-1)
CNT_W, 8, width of wait counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
inRegwrite  input  1  EX/MEM regwrite
inMemtoreg  input  1  EX/MEM memtoreg
inMemwrite  input  1  EX/MEM store request
inMemread  input  1  EX/MEM load request
inResult  input  32  ALU result / byte address
inForward  input  32  store data
inRdout  input  5  destination register
memReq  output  1  memory request, registered
memWe  output  1  1=write, 0=read, valid with memReq
memAddr  output  32  word-aligned address
memWdata  output  32  store data
memRdata  input  32  load data, valid with memAck
memAck  input  1  one-cycle completion, sampled only while memReq=1
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; combinational
memErr  output  1  sticky error (timeout or misaligned)
outRegwrite  output  1  MEM/WB regwrite
outMemtoreg  output  1  MEM/WB memtoreg
outReadData  output  32  MEM/WB load data
outResult  output  32  MEM/WB ALU result
MemWbRd  output  5  MEM/WB destination register

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, wait counter=0, memErr=0.
  - memReq, memWe, memAddr, memWdata = 0.
  - All MEM/WB outputs = 0.
  - rst overrides everything, including mid-ACCESS: memReq drops at that edge and no ack is honoured afterwards.
- Signal definitions:
  - access = inMemread | inMemwrite.
  - Both asserted counts as a write (memWe=1); outReadData=0.
  - misaligned = access & (inResult[1:0] != 0).
- FSM IDLE / ACCESS.
- IDLE, no access:
  - stall=0.
  - MEM/WB loads inputs at next edge, outReadData=0.
  - 1-cycle latency.
- IDLE, misaligned:
  - No request, stall=0.
  - memErr<=1.
  - MEM/WB loads with outRegwrite=0 (squashed).
- IDLE, aligned access:
  - stall=1 combinationally.
  - Next edge: state<=ACCESS, memReq<=1, memWe<=inMemwrite, memAddr<=inResult, memWdata<=inForward, counter<=0.
  - MEM/WB loads a bubble: all control 0, data 0.
- ACCESS, memAck=0:
  - stall=1; memReq and payload held stable.
  - counter increments.
  - MEM/WB loads a bubble each edge.
- ACCESS, memAck=1:
  - stall=0 that cycle.
  - Next edge: MEM/WB loads inRegwrite, inMemtoreg, inResult, inRdout, and outReadData<=memRdata (reads) or 0 (writes).
  - Same edge: memReq<=0, state<=IDLE.
  - Minimum load/store cost is one stall cycle (ack in first ACCESS cycle).
- ACCESS, counter == TIMEOUT_CYCLES-1 and memAck=0:
  - Abort: stall=0 that cycle.
  - Next edge: memErr<=1, memReq<=0, state<=IDLE.
  - MEM/WB loads with outRegwrite=0 (squashed).
- Back-to-back accesses: the IDLE cycle following completion already sees the next EX/MEM entry, so at most one request per two cycles; memReq is low for at least one cycle between requests.
- memAck while memReq=0 is ignored.
- memErr clears only on rst.
- Counter saturates; it never wraps.

Test Plan:
- Reset: rst=1 for 2 cycles mid-ACCESS -> memReq=0, stall=0, all outputs 0, state IDLE.
- ALU op: inRegwrite=1, inResult=0x0000_00AA, inRdout=5, no mem -> next edge outRegwrite=1, outResult=0xAA, MemWbRd=5, stall never 1.
- Load, 3-cycle memory: inMemread=1, inResult=0x100, ack on 3rd ACCESS cycle with memRdata=0xDEADBEEF -> stall high 3 cycles, memAddr=0x100, memWe=0, then outReadData=0xDEADBEEF, outMemtoreg=1; bubbles (outRegwrite=0) during stall.
- Store, zero-wait: inMemwrite=1, inResult=0x204, inForward=0x12345678, ack in first ACCESS cycle -> one stall cycle, memWe=1, memWdata=0x12345678, outReadData=0.
- Timeout with TIMEOUT_CYCLES=4: load, no ack -> memReq high exactly 4 cycles, then memErr=1, stall=0, outRegwrite=0; a later stray memAck is ignored.
- Misaligned: inMemread=1, inResult=0x102 -> memReq stays 0, memErr=1, outRegwrite=0, no stall.
